cfar_threshold_gen: RTL and testbench
=====================================

# cfar_threshold_gen

Cell-averaging CFAR threshold generator for the STFT magnitude stream. It consumes one magnitude bin per enabled cycle and delays each bin to the centre of a sliding window. For that centre cell (the cell under test, CUT) it outputs the bin value together with a threshold: the mean of the training cells times a programmable scale. It sits directly upstream of the threshold comparator, and `oDATA`, `oTH` and `oEN` connect one-to-one to the comparator's data, threshold and enable inputs.

## Interface
Parameters:
- `IL`, 10: magnitude and threshold width.
- `NT`, 8: training cells per side; must be a power of 2 and ≥ 2.
- `NG`, 2: guard cells per side; ≥ 0.
- `NBIN`, 64: bins per STFT column (frame); must be > 2·(NT+NG).

Ports:
- `iCLK`  in  1: clock.
- `iRSTn`  in  1: reset, asynchronous, active-low.
- `iEN`  in  1: `iDATA` valid this cycle; one bin accepted per high cycle.
- `iDATA`  in  IL: magnitude bin, unsigned; bin 0 first within each frame.
- `iSCALE`  in  4: threshold scale, unsigned Q2.2 (4 = 1.0, 15 = 3.75); held stable during a frame.
- `oDATA`  out  IL: CUT magnitude.
- `oTH`  out  IL: threshold for the CUT.
- `oEN`  out  1: `oDATA`/`oTH` valid, one-cycle pulse.

## Operation
- Window length is W = 2·(NT+NG)+1. Shift register `win[0..W-1]`, with `win[0]` the newest. On each `iEN` it shifts by one and loads `iDATA` into `win[0]`.
- CUT = `win[NT+NG]`.
- Lead training cells are `win[0..NT-1]`. Lag training cells are `win[NT+2NG+1..W-1]`. Guard cells are excluded from both sums.
- Running sums, updated on each `iEN`:
  - `lead += iDATA − win[NT-1]`
  - `lag += win[NT+2NG] − win[W-1]`
  - Each sum is IL+log2(NT) bits wide, unsigned, and never underflows.
- Average: `avg = (lead+lag) >> log2(2·NT)`, truncating.
- Threshold: `th = (avg · iSCALE) >> 2`, computed at IL+4 bits, truncating. If th > 2^IL−1, saturate to 2^IL−1.
- CUT bin index `cidx` counts 0..NBIN−1 and wraps. It advances on each emitted output and starts at 0 at the first output after reset.
- Edge cells: when `cidx < NT+NG` or `cidx > NBIN−1−NT−NG`, the window straddles a frame boundary. In that case force `oTH = 2^IL−1` so the CUT is never detected. `oDATA` is still the CUT value.
- Priming: count accepted samples after reset, saturating at NT+NG+1. `oEN` stays low until that count reaches NT+NG+1; at that point the CUT is bin 0 of the first frame.
- There is no end-of-frame flush. The last NT+NG bins of a frame are emitted as the next frame's bins are accepted.

## Timing
- Reset values: `oDATA`=0, `oTH`=0, `oEN`=0. All window entries, sums, `cidx` and the prime counter are 0.
- Asserting `iRSTn` low mid-frame clears all state immediately, with no completion of in-flight outputs. After release, operation restarts at bin 0 with a new priming phase.
- Latency: if `iEN` is high in cycle t, then from cycle t+1 onward `oEN`=1 for exactly one cycle (once primed). That output carries the CUT = the sample accepted NT+NG acceptances earlier.
- Input bubbles (`iEN` low) freeze all state, and `oEN` is low in the following cycle. `oDATA`/`oTH` hold their last values while `oEN` is low.
- `iSCALE` is sampled in the same cycle as the window update that produces the output.
- Throughput is one bin per cycle, and there is no backpressure.

## Structure
- Shared package constants:
  - W
  - log2(NT)
  - sum width IL+log2(NT)
  - product width IL+4
  - saturation value 2^IL−1
  - edge bounds NT+NG and NBIN−1−NT−NG
- Sub-module `cfar_window`: shift register plus the two running sums. Outputs are CUT, `lead` and `lag`.
- The top level holds the average/scale/saturation output stage, `cidx`, the prime counter and the edge masking.

## Test plan
Defaults for all scenarios: IL=10, NT=8, NG=2, NBIN=64.
- **Flat input:** constant 100 on all bins, `iSCALE`=4, continuous `iEN` → `cidx` 10..53 give `oTH`=100, `oDATA`=100; `cidx` 0..9 and 54..63 give `oTH`=1023.
- **Single spike:** floor 50 with bin 32 = 800, `iSCALE`=12 → at `cidx` 32, `oDATA`=800, `oTH`=150; at `cidx` 22..29 (spike in training), sum=1550, `avg`=96, `oTH`=288.
- **Saturation:** all bins 1000, `iSCALE`=15 → interior `oTH`=1023 (raw 3750 saturated).
- **Input bubbles:** flat/spike streams with random `iEN` gaps → sequence of (`oDATA`, `oTH`) identical to the gap-free run; each `oEN` exactly 1 cycle after its accepting `iEN`; no `oEN` during gaps.
- **Reset mid-frame:** assert `iRSTn` low at input bin 40 → same cycle `oEN`/`oTH`/`oDATA`=0; after release no `oEN` for the first 10 accepted samples; 11th accepted sample gives `oEN`=1 with `cidx`=0, CUT = first post-reset sample, `oTH`=1023.

Source files
------------

// File: rtl/cfar_threshold_gen_pkg.sv
// Shared constants and sizing helpers for the CA-CFAR threshold generator.
// Defaults match the nominal STFT configuration; helpers derive the rest.
package cfar_threshold_gen_pkg;

  localparam int CFAR_IL   = 10;
  localparam int CFAR_NT   = 8;
  localparam int CFAR_NG   = 2;
  localparam int CFAR_NBIN = 64;

  function automatic int win_len(input int nt, input int ng);
    return 2 * (nt + ng) + 1;
  endfunction

  function automatic int nt_log2(input int nt);
    return $clog2(nt);
  endfunction

  function automatic int sum_w(input int il, input int nt);
    return il + $clog2(nt);
  endfunction

  function automatic int prod_w(input int il);
    return il + 4;
  endfunction

  function automatic int sat_val(input int il);
    return (1 << il) - 1;
  endfunction

  function automatic int edge_lo(input int nt, input int ng);
    return nt + ng;
  endfunction

  function automatic int edge_hi(input int nbin, input int nt,
                                 input int ng);
    return nbin - 1 - nt - ng;
  endfunction

  localparam int CFAR_W    = win_len(CFAR_NT, CFAR_NG);
  localparam int CFAR_LNT  = nt_log2(CFAR_NT);
  localparam int CFAR_SW   = sum_w(CFAR_IL, CFAR_NT);
  localparam int CFAR_PW   = prod_w(CFAR_IL);
  localparam int CFAR_SAT  = sat_val(CFAR_IL);
  localparam int CFAR_ELO  = edge_lo(CFAR_NT, CFAR_NG);
  localparam int CFAR_EHI  = edge_hi(CFAR_NBIN, CFAR_NT, CFAR_NG);

endpackage

// File: rtl/cfar_threshold_gen_if.sv
// Magnitude-in / CUT-plus-threshold-out bundle of the CFAR generator.
// master drives bins and scale; slave returns CUT, threshold, valid.
interface cfar_threshold_gen_if #(
  parameter int IL = 10
);

  logic          iEN;
  logic [IL-1:0] iDATA;
  logic [3:0]    iSCALE;
  logic [IL-1:0] oDATA;
  logic [IL-1:0] oTH;
  logic          oEN;

  modport master (
    output iEN, iDATA, iSCALE,
    input  oDATA, oTH, oEN
  );

  modport slave (
    input  iEN, iDATA, iSCALE,
    output oDATA, oTH, oEN
  );

endinterface

// File: rtl/cfar_window.sv
// Sliding CFAR window: shift register plus lead/lag training sums.
// Outputs are the post-update values so the caller can register them.
module cfar_window
  import cfar_threshold_gen_pkg::*;
#(
  parameter  int IL = CFAR_IL,
  parameter  int NT = CFAR_NT,
  parameter  int NG = CFAR_NG,
  localparam int W  = win_len(NT, NG),
  localparam int SW = sum_w(IL, NT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [IL-1:0] data_i,
  output logic [IL-1:0] cut_o,
  output logic [SW-1:0] lead_o,
  output logic [SW-1:0] lag_o
);

  logic [IL-1:0] win_q [W];
  logic [IL-1:0] win_d [W];
  logic [SW-1:0] lead_q, lead_d;
  logic [SW-1:0] lag_q, lag_d;

  // Sums may wrap mid-expression; the true result always fits in SW bits.
  always_comb begin
    win_d  = win_q;
    lead_d = lead_q;
    lag_d  = lag_q;
    if (en_i) begin
      win_d[0] = data_i;
      for (int i = 1; i < W; i++) begin
        win_d[i] = win_q[i-1];
      end
      lead_d = lead_q + SW'(data_i)
             - SW'(win_q[NT-1]);
      lag_d  = lag_q + SW'(win_q[NT+2*NG])
             - SW'(win_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        win_q[i] <= '0;
      end
      lead_q <= '0;
      lag_q  <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        win_q[i] <= win_d[i];
      end
      lead_q <= lead_d;
      lag_q  <= lag_d;
    end
  end

  assign cut_o  = win_d[NT+NG];
  assign lead_o = lead_d;
  assign lag_o  = lag_d;

endmodule

// File: rtl/cfar_threshold_gen.sv
// Cell-averaging CFAR threshold generator for the STFT magnitude stream.
// Emits the CUT and its scaled training mean, masked at frame edges.
module cfar_threshold_gen
  import cfar_threshold_gen_pkg::*;
#(
  parameter int IL   = CFAR_IL,
  parameter int NT   = CFAR_NT,
  parameter int NG   = CFAR_NG,
  parameter int NBIN = CFAR_NBIN
) (
  input  logic iCLK,
  input  logic iRSTn,
  cfar_threshold_gen_if.slave bus
);

  localparam int SW    = sum_w(IL, NT);
  localparam int PW    = prod_w(IL);
  localparam int SH    = nt_log2(NT) + 1;
  localparam int PRIME = NT + NG + 1;
  localparam int PCW   = $clog2(PRIME + 1);
  localparam int CW    = $clog2(NBIN);

  localparam logic [IL-1:0]  SAT    = IL'(sat_val(IL));
  localparam logic [CW-1:0]  ELO    = CW'(edge_lo(NT, NG));
  localparam logic [CW-1:0]  EHI    = CW'(edge_hi(NBIN, NT, NG));
  localparam logic [CW-1:0]  LAST   = CW'(NBIN - 1);
  localparam logic [PCW-1:0] PRIMED = PCW'(PRIME);

  logic [IL-1:0] cut;
  logic [SW-1:0] lead, lag;

  cfar_window #(
    .IL (IL),
    .NT (NT),
    .NG (NG)
  ) u_win (
    .clk    (iCLK),
    .rst_n  (iRSTn),
    .en_i   (bus.iEN),
    .data_i (bus.iDATA),
    .cut_o  (cut),
    .lead_o (lead),
    .lag_o  (lag)
  );

  logic [SW:0]   sum;
  logic [IL-1:0] avg;
  logic [PW-1:0] prod;
  logic [PW-1:0] th_raw;
  logic [IL-1:0] th;
  logic          edge_cell;
  logic          fire;

  logic [PCW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]  cidx_q, cidx_d;
  logic [IL-1:0]  data_q, data_d;
  logic [IL-1:0]  th_q, th_d;
  logic           en_q, en_d;

  always_comb begin
    sum    = {1'b0, lead} + {1'b0, lag};
    avg    = IL'(sum >> SH);
    prod   = PW'(avg) * PW'(bus.iSCALE);
    th_raw = prod >> 2;
    th     = (|th_raw[PW-1:IL]) ? SAT : IL'(th_raw);
  end

  // Windows touching a neighbouring frame must never detect.
  assign edge_cell = (cidx_q < ELO) || (cidx_q > EHI);
  assign fire = bus.iEN && (cnt_q >= PRIMED - PCW'(1));

  always_comb begin
    cnt_d  = cnt_q;
    cidx_d = cidx_q;
    data_d = data_q;
    th_d   = th_q;
    en_d   = 1'b0;
    if (bus.iEN && cnt_q != PRIMED) begin
      cnt_d = cnt_q + PCW'(1);
    end
    if (fire) begin
      en_d   = 1'b1;
      data_d = cut;
      th_d   = edge_cell ? SAT : th;
      cidx_d = (cidx_q == LAST) ? '0 : cidx_q + CW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_q  <= '0;
      cidx_q <= '0;
      data_q <= '0;
      th_q   <= '0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cidx_q <= cidx_d;
      data_q <= data_d;
      th_q   <= th_d;
      en_q   <= en_d;
    end
  end

  assign bus.oDATA = data_q;
  assign bus.oTH   = th_q;
  assign bus.oEN   = en_q;

endmodule

// File: tb/tb_cfar_threshold_gen.sv
// Directed bench for cfar_threshold_gen: flat, spike, saturation,
// bubbles and mid-frame reset against a sliding-window reference.
module tb_cfar_threshold_gen;

  localparam int IL = 10;

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b1;

  always #5 iCLK = ~iCLK;

  cfar_threshold_gen_if #(.IL(IL)) bus ();

  cfar_threshold_gen #(
    .IL   (IL),
    .NT   (8),
    .NG   (2),
    .NBIN (64)
  ) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int hist [0:4095];
  int pat [0:63];
  int cap_d [0:63];
  int cap_th [0:63];
  int acc, ocnt, scale, last_d, last_th;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference from the window definition: sample n is the newest.
  function automatic int exp_th(input int n, input int k);
    int s, t;
    s = 0;
    if (k < 10 || k > 53) return 1023;
    for (int i = 0; i < 8; i++) s += hist[n-i] + hist[n-13-i];
    t = ((s / 16) * scale) / 4;
    return (t > 1023) ? 1023 : t;
  endfunction

  task automatic cycle(input bit en, input int d);
    int k, ed, et;
    bus.iEN    = en;
    bus.iDATA  = IL'(d);
    bus.iSCALE = 4'(scale);
    @(posedge iCLK);
    #1;
    if (en) begin
      acc++;
      hist[acc] = d;
    end
    if (en && acc >= 11) begin
      k  = ocnt % 64;
      ed = hist[acc-10];
      et = exp_th(acc, k);
      chk("oen_out", {31'b0, bus.oEN}, 1);
      chk("odata", {22'b0, bus.oDATA}, ed);
      chk("oth", {22'b0, bus.oTH}, et);
      cap_d[k]  = int'(bus.oDATA);
      cap_th[k] = int'(bus.oTH);
      last_d  = ed;
      last_th = et;
      ocnt++;
    end else begin
      chk("oen_idle", {31'b0, bus.oEN}, 0);
      chk("odata_hold", {22'b0, bus.oDATA}, last_d);
      chk("oth_hold", {22'b0, bus.oTH}, last_th);
    end
  endtask

  task automatic run(input int nf, input bit gaps, input int stop);
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < 64; b++) begin
        if (f * 64 + b == stop) return;
        if (gaps) repeat ($urandom_range(0, 2)) cycle(0, 0);
        cycle(1, pat[b]);
      end
    end
  endtask

  initial begin
    bus.iEN = 1'b0;
    bus.iDATA = '0;
    bus.iSCALE = 4'd4;
    acc = 0; ocnt = 0; scale = 4;
    last_d = 0; last_th = 0;

    #2 iRSTn = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_oen", {31'b0, bus.oEN}, 0);
    chk("rst_odata", {22'b0, bus.oDATA}, 0);
    chk("rst_oth", {22'b0, bus.oTH}, 0);
    @(negedge iCLK);
    iRSTn = 1'b1;

    for (int i = 0; i < 64; i++) pat[i] = 100;
    scale = 4;
    run(2, 1'b0, -1);
    chk("flat_th10", cap_th[10], 100);
    chk("flat_th53", cap_th[53], 100);
    chk("flat_d30", cap_d[30], 100);
    chk("flat_th0", cap_th[0], 1023);
    chk("flat_th9", cap_th[9], 1023);
    chk("flat_th54", cap_th[54], 1023);
    chk("flat_th63", cap_th[63], 1023);

    for (int i = 0; i < 64; i++) pat[i] = 50;
    pat[32] = 800;
    scale = 12;
    run(2, 1'b0, -1);
    chk("spk_d32", cap_d[32], 800);
    chk("spk_th32", cap_th[32], 150);
    chk("spk_th22", cap_th[22], 288);
    chk("spk_th29", cap_th[29], 288);
    chk("spk_th21", cap_th[21], 150);
    chk("spk_th30", cap_th[30], 150);

    for (int i = 0; i < 64; i++) pat[i] = 1000;
    scale = 15;
    run(2, 1'b0, -1);
    chk("sat_th30", cap_th[30], 1023);
    chk("sat_d30", cap_d[30], 1000);

    for (int i = 0; i < 64; i++) pat[i] = 50;
    pat[32] = 800;
    scale = 12;
    run(2, 1'b1, -1);
    chk("gap_d32", cap_d[32], 800);
    chk("gap_th32", cap_th[32], 150);
    chk("gap_th25", cap_th[25], 288);

    run(1, 1'b0, 40);
    iRSTn = 1'b0;
    bus.iEN = 1'b0;
    #1;
    chk("mid_rst_oen", {31'b0, bus.oEN}, 0);
    chk("mid_rst_oth", {22'b0, bus.oTH}, 0);
    chk("mid_rst_odata", {22'b0, bus.oDATA}, 0);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRSTn = 1'b1;
    acc = 0; ocnt = 0;
    last_d = 0; last_th = 0;

    for (int i = 0; i < 64; i++) pat[i] = 200 + i;
    scale = 4;
    run(1, 1'b0, -1);
    chk("post_d0", cap_d[0], 200);
    chk("post_th0", cap_th[0], 1023);
    chk("post_d10", cap_d[10], 210);
    chk("post_th10", cap_th[10], 210);
    chk("post_nout", ocnt, 54);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
